// File: rtl/event_hash_window_store.sv
// Hashed sparse event store: single-event writes, full WxW neighbourhood reads.
// Entries are flops (async-cleared valid bits, many parallel read ports).
module event_hash_window_store #(
  parameter int DATA_WIDTH       = 4,
  parameter int MEM_DEPTH        = 256,
  parameter int HALF_WINDOW_SIZE = 1,
  parameter int HASH_ROW_STRIDE  = 16,
  localparam int WINDOW_SIZE     = 2 * HALF_WINDOW_SIZE + 1
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [DATA_WIDTH-1:0]                            in_event_value,
  input  logic [15:0]                                      in_event_addr,
  input  logic                                             in_event_valid,
  input  logic [15:0]                                      out_window_addr,
  input  logic                                             read_req,
  output logic                                             write_done,
  output logic [WINDOW_SIZE*WINDOW_SIZE*DATA_WIDTH-1:0]    out_window_value,
  output logic                                             out_window_valid
);

  localparam int IW = $clog2(MEM_DEPTH);
  localparam int NW = WINDOW_SIZE * WINDOW_SIZE;

  typedef struct packed {
    logic                  valid;
    logic [15:0]           tag;
    logic [DATA_WIDTH-1:0] value;
  } entry_t;

  // MEM_DEPTH is a power of two, so the modulo is a plain truncation.
  function automatic logic [IW-1:0] hash_idx(input logic [15:0] addr);
    return IW'(32'(addr[7:0]) + 32'(addr[15:8]) * 32'(HASH_ROW_STRIDE));
  endfunction

  entry_t                     mem_rd [MEM_DEPTH];
  logic [IW-1:0]              wr_idx;
  logic [DATA_WIDTH-1:0]      slice_val [NW];

  logic                       write_done_q, write_done_d;
  logic                       window_valid_q, window_valid_d;
  logic [NW*DATA_WIDTH-1:0]   window_value_q, window_value_d;

  assign wr_idx = hash_idx(in_event_addr);

  genvar gi;
  generate
    for (gi = 0; gi < MEM_DEPTH; gi++) begin : g_entry
      entry_t entry_q, entry_d;

      always_comb begin
        entry_d = entry_q;
        if (in_event_valid && wr_idx == IW'(gi)) begin
          entry_d = '{valid: 1'b1, tag: in_event_addr, value: in_event_value};
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) entry_q <= '0;
        else        entry_q <= entry_d;
      end

      assign mem_rd[gi] = entry_q;
    end

    // One lookup per window slot; stride > 2H keeps the slot indices distinct.
    for (gi = 0; gi < NW; gi++) begin : g_slot
      localparam int ROW_OFS = gi / WINDOW_SIZE - HALF_WINDOW_SIZE;
      localparam int COL_OFS = gi % WINDOW_SIZE - HALF_WINDOW_SIZE;
      localparam logic [15:0] OFFSET = 16'(ROW_OFS * 256 + COL_OFS);

      logic [15:0] rd_addr;
      entry_t      rd_entry;

      assign rd_addr       = out_window_addr + OFFSET;
      assign rd_entry      = mem_rd[hash_idx(rd_addr)];
      assign slice_val[gi] = (rd_entry.valid && rd_entry.tag == rd_addr) ? rd_entry.value : '0;
    end
  endgenerate

  always_comb begin
    write_done_d   = in_event_valid;
    window_valid_d = read_req;
    window_value_d = window_value_q;
    if (read_req) begin
      for (int k = 0; k < NW; k++) begin
        window_value_d[k*DATA_WIDTH +: DATA_WIDTH] = slice_val[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_done_q   <= 1'b0;
      window_valid_q <= 1'b0;
      window_value_q <= '0;
    end else begin
      write_done_q   <= write_done_d;
      window_valid_q <= window_valid_d;
      window_value_q <= window_value_d;
    end
  end

  assign write_done       = write_done_q;
  assign out_window_valid = window_valid_q;
  assign out_window_value = window_value_q;

endmodule

// File: tb/tb_event_hash_window_store.sv
// Bench for event_hash_window_store: directed cases plus random traffic
// checked against an address-keyed model with hash-slot ownership for eviction.
module tb_event_hash_window_store;

  localparam int DW = 4;
  localparam int W  = 3;
  localparam int NW = W * W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     in_event_value = '0;
  logic [15:0]       in_event_addr = '0;
  logic              in_event_valid = 1'b0;
  logic [15:0]       out_window_addr = '0;
  logic              read_req = 1'b0;
  logic              write_done;
  logic [NW*DW-1:0]  out_window_value;
  logic              out_window_valid;

  event_hash_window_store dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_event_value   (in_event_value),
    .in_event_addr    (in_event_addr),
    .in_event_valid   (in_event_valid),
    .out_window_addr  (out_window_addr),
    .read_req         (read_req),
    .write_done       (write_done),
    .out_window_value (out_window_value),
    .out_window_valid (out_window_valid)
  );

  always #5 clk = ~clk;

  int pass_count  = 0;
  int check_count = 0;

  int live  [int];   // address -> value of every event still retrievable
  int owner [int];   // hash slot -> address currently occupying it
  logic [NW*DW-1:0] exp_window = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int model_slot(input int addr);
    return ((addr & 255) + ((addr >> 8) & 255) * 16) % 256;
  endfunction

  function automatic logic [NW*DW-1:0] model_window(input int centre);
    logic [NW*DW-1:0] w;
    w = '0;
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        int a;
        a = (centre + (r - 1) * 256 + (c - 1)) & 16'hFFFF;
        if (live.exists(a)) w[(r*W+c)*DW +: DW] = DW'(live[a]);
      end
    end
    return w;
  endfunction

  task automatic model_write(input int addr, input int val);
    int s;
    s = model_slot(addr);
    if (owner.exists(s) && live.exists(owner[s])) live.delete(owner[s]);
    owner[s]   = addr;
    live[addr] = val;
  endtask

  task automatic model_reset();
    live.delete();
    owner.delete();
    exp_window = '0;
  endtask

  // One clock of traffic: drive, let the edge pass, update the model, compare.
  task automatic cycle(input bit we, input logic [15:0] wa, input logic [DW-1:0] wv,
                       input bit re, input logic [15:0] ra, input string tag);
    in_event_valid  = we;
    in_event_addr   = wa;
    in_event_value  = wv;
    read_req        = re;
    out_window_addr = ra;
    @(posedge clk);
    if (re) exp_window = model_window(int'(ra));
    if (we) model_write(int'(wa), int'(wv));
    #1;
    $display("%s: we=%0d wa=%h wv=%0d re=%0d ra=%h -> done=%0d valid=%0d win=%h",
             tag, we, wa, wv, re, ra, write_done, out_window_valid, out_window_value);
    check_val({tag, ".write_done"}, 64'(write_done), 64'(we));
    check_val({tag, ".win_valid"}, 64'(out_window_valid), 64'(re));
    check_val({tag, ".win_value"}, 64'(out_window_value), 64'(exp_window));
  endtask

  task automatic idle();
    cycle(1'b0, 16'h0, 4'h0, 1'b0, 16'h0, "idle");
  endtask

  initial begin
    logic [15:0] wa, ra;
    #12;
    check_val("rst.write_done", 64'(write_done), 64'd0);
    check_val("rst.win_valid", 64'(out_window_valid), 64'd0);
    check_val("rst.win_value", 64'(out_window_value), 64'd0);
    rst_n = 1'b1;

    cycle(0, 16'h0, 4'h0, 1, 16'h0304, "empty_read");
    check_val("empty_read.all0", 64'(out_window_value), 64'd0);

    cycle(1, 16'h0305, 4'd7, 0, 16'h0, "wr_0305");
    cycle(0, 16'h0, 4'h0, 1, 16'h0304, "rd_0304");
    check_val("rd_0304.slice5", 64'(out_window_value[23:20]), 64'd7);
    check_val("rd_0304.others", 64'(out_window_value & ~(36'hF << 20)), 64'd0);
    cycle(0, 16'h0, 4'h0, 1, 16'h0406, "rd_0406");
    check_val("rd_0406.slice0", 64'(out_window_value[3:0]), 64'd7);
    idle();
    check_val("hold.win_value", 64'(out_window_value[3:0]), 64'd7);

    cycle(1, 16'h1305, 4'd9, 0, 16'h0, "wr_1305");
    cycle(0, 16'h0, 4'h0, 1, 16'h0305, "rd_0305_evicted");
    check_val("evict.slice4", 64'(out_window_value[19:16]), 64'd0);
    cycle(0, 16'h0, 4'h0, 1, 16'h1305, "rd_1305");
    check_val("collide.slice4", 64'(out_window_value[19:16]), 64'd9);

    cycle(1, 16'h0305, 4'd7, 0, 16'h0, "wr_0305_again");
    cycle(1, 16'h0305, 4'd2, 0, 16'h0, "wr_0305_upd");
    cycle(0, 16'h0, 4'h0, 1, 16'h0305, "rd_0305_upd");
    check_val("update.slice4", 64'(out_window_value[19:16]), 64'd2);

    cycle(1, 16'hFFFF, 4'd3, 0, 16'h0, "wr_ffff");
    cycle(0, 16'h0, 4'h0, 1, 16'h0000, "rd_wrap");
    check_val("wrap.slice3", 64'(out_window_value[15:12]), 64'd3);
    cycle(1, 16'hFFFF, 4'd8, 1, 16'h0000, "wr_rd_same");
    check_val("same_edge.old", 64'(out_window_value[15:12]), 64'd3);
    cycle(0, 16'h0, 4'h0, 1, 16'h0000, "rd_after");
    check_val("same_edge.new", 64'(out_window_value[15:12]), 64'd8);

    // Asynchronous reset in the middle of a write_done pulse.
    cycle(1, 16'h0101, 4'd5, 1, 16'h0000, "wr_0101");
    in_event_valid = 1'b0;
    read_req       = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst.write_done", 64'(write_done), 64'd0);
    check_val("async_rst.win_valid", 64'(out_window_valid), 64'd0);
    check_val("async_rst.win_value", 64'(out_window_value), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 16'h0, 4'h0, 1, 16'h0101, "rd_0101_after_rst");
    check_val("after_rst.all0", 64'(out_window_value), 64'd0);

    // Random traffic focused on a small region, with rows 16 apart to force collisions.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        wa = 16'($urandom);
        ra = 16'($urandom);
      end else begin
        wa = {8'($urandom_range(2, 5) + 16 * $urandom_range(0, 1)), 8'($urandom_range(0, 6))};
        ra = {8'($urandom_range(2, 5) + 16 * $urandom_range(0, 1)), 8'($urandom_range(0, 6))};
      end
      cycle(1'($urandom_range(0, 1)), wa, 4'($urandom), 1'($urandom_range(0, 1)), ra, "rand");
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
